// File: rtl/ysyx_25040129_idu_operand_stage_if.sv
// rtl/ysyx_25040129_idu_operand_stage_if.sv - decode-side and EXU-side handshake bundle for the operand stage
interface ysyx_25040129_idu_operand_stage_if #(
    parameter int XLEN      = 32,
    parameter int REG_AW    = 4,
    parameter int PAYLOAD_W = 64
);
    // decode -> stage
    logic                 in_valid;
    logic                 in_ready;
    logic [REG_AW-1:0]    in_rs1;
    logic [REG_AW-1:0]    in_rs2;
    logic                 in_rs1_used;
    logic                 in_rs2_used;
    logic [REG_AW-1:0]    in_rd;
    logic                 in_rd_we;
    logic [PAYLOAD_W-1:0] in_payload;

    // stage -> EXU
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_src1;
    logic [XLEN-1:0]      out_src2;
    logic [REG_AW-1:0]    out_rd;
    logic                 out_rd_we;
    logic [PAYLOAD_W-1:0] out_payload;

    // the environment around the stage: drives decoded instructions, consumes issued ones
    modport master (
        output in_valid, in_rs1, in_rs2, in_rs1_used, in_rs2_used, in_rd, in_rd_we, in_payload,
        input  in_ready,
        input  out_valid, out_src1, out_src2, out_rd, out_rd_we, out_payload,
        output out_ready
    );

    // the operand stage itself
    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rs1_used, in_rs2_used, in_rd, in_rd_we, in_payload,
        output in_ready,
        output out_valid, out_src1, out_src2, out_rd, out_rd_we, out_payload,
        input  out_ready
    );
endinterface

// File: rtl/ysyx_25040129_idu_operand_stage.sv
// rtl/ysyx_25040129_idu_operand_stage.sv - operand resolve, RAW hazard check and issue buffer between decode and EXU
module ysyx_25040129_idu_operand_stage #(
    parameter int XLEN        = 32,
    parameter int REG_AW      = 4,
    parameter int NUM_FWD     = 3,
    parameter int DEPTH       = 2,
    parameter int PAYLOAD_W   = 64,
    parameter int STALL_LIMIT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    ysyx_25040129_idu_operand_stage_if.slave bus,
    input  logic [XLEN-1:0]           rf_rdata1,
    input  logic [XLEN-1:0]           rf_rdata2,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [NUM_FWD-1:0]        fwd_data_valid,
    input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
    input  logic                      flush,
    output logic [7:0]                stall_cycles,
    output logic                      stall_timeout
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // issue buffer storage; vld_q marks occupied slots so the scoreboard only sees live entries
    logic [XLEN-1:0]      src1_q    [DEPTH];
    logic [XLEN-1:0]      src2_q    [DEPTH];
    logic [REG_AW-1:0]    rd_q      [DEPTH];
    logic                 rd_we_q   [DEPTH];
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];
    logic                 vld_q     [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    stall_q, stall_d;

    // per-source view: index 0 = rs1, index 1 = rs2
    logic [REG_AW-1:0] src_idx [2];
    logic [XLEN-1:0]   src_rf  [2];
    logic [XLEN-1:0]   src_val [2];
    logic [XLEN-1:0]   fwd_sel [2];
    logic [1:0]        src_used;
    logic [1:0]        src_hz;
    logic [1:0]        buf_hit;
    logic [1:0]        fwd_hit;
    logic [1:0]        fwd_dv_sel;

    logic hazard;
    logic in_ready_w;
    logic out_valid_w;
    logic push;
    logic pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign src_idx[0] = bus.in_rs1;
    assign src_idx[1] = bus.in_rs2;
    assign src_rf[0]  = rf_rdata1;
    assign src_rf[1]  = rf_rdata2;
    assign src_used   = {bus.in_rs2_used, bus.in_rs1_used};

    // Resolve each source: any live buffer writer of rs is younger than every channel, so it wins as a hazard;
    // otherwise the lowest-numbered matching channel decides between forwarding and stalling.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            buf_hit[s]    = 1'b0;
            fwd_hit[s]    = 1'b0;
            fwd_dv_sel[s] = 1'b0;
            fwd_sel[s]    = '0;
            src_val[s]    = src_rf[s];
            src_hz[s]     = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                if (vld_q[i] && rd_we_q[i] && (rd_q[i] == src_idx[s])) begin
                    buf_hit[s] = 1'b1;
                end
            end
            for (int c = NUM_FWD - 1; c >= 0; c--) begin
                if (fwd_we[c] && (fwd_rd[c*REG_AW +: REG_AW] == src_idx[s])) begin
                    fwd_hit[s]    = 1'b1;
                    fwd_dv_sel[s] = fwd_data_valid[c];
                    fwd_sel[s]    = fwd_data[c*XLEN +: XLEN];
                end
            end
            if (src_used[s] && (src_idx[s] != '0)) begin
                if (buf_hit[s]) begin
                    src_hz[s] = 1'b1;
                end else if (fwd_hit[s]) begin
                    if (fwd_dv_sel[s]) begin
                        src_val[s] = fwd_sel[s];
                    end else begin
                        src_hz[s] = 1'b1;
                    end
                end
            end
        end
    end

    assign hazard      = bus.in_valid & (src_hz[0] | src_hz[1]);
    assign out_valid_w = (count_q != '0);
    assign in_ready_w  = (count_q != CW'(DEPTH)) & ~hazard & ~flush;
    assign push        = bus.in_valid & in_ready_w;
    assign pop         = out_valid_w & bus.out_ready;

    // Next-state for pointers, occupancy and the stall counter; flush overrides everything
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        stall_d = stall_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            stall_d = '0;
        end else begin
            if (push) begin
                tail_d = ptr_inc(tail_q);
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (!bus.in_valid || push) begin
                stall_d = '0;
            end else if (hazard && (stall_q != 8'(STALL_LIMIT))) begin
                stall_d = stall_q + 8'd1;
            end
        end
    end

    // State registers and buffer writes; reset clears payload storage so the outputs read zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            stall_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                src1_q[i]    <= '0;
                src2_q[i]    <= '0;
                rd_q[i]      <= '0;
                rd_we_q[i]   <= 1'b0;
                payload_q[i] <= '0;
                vld_q[i]     <= 1'b0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            stall_q <= stall_d;
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    vld_q[i] <= 1'b0;
                end
            end else begin
                if (push) begin
                    src1_q[tail_q]    <= src_val[0];
                    src2_q[tail_q]    <= src_val[1];
                    rd_q[tail_q]      <= bus.in_rd;
                    rd_we_q[tail_q]   <= bus.in_rd_we;
                    payload_q[tail_q] <= bus.in_payload;
                    vld_q[tail_q]     <= 1'b1;
                end
                if (pop) begin
                    vld_q[head_q] <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready    = in_ready_w;
    assign bus.out_valid   = out_valid_w;
    assign bus.out_src1    = src1_q[head_q];
    assign bus.out_src2    = src2_q[head_q];
    assign bus.out_rd      = rd_q[head_q];
    assign bus.out_rd_we   = rd_we_q[head_q];
    assign bus.out_payload = payload_q[head_q];
    assign stall_cycles    = stall_q;
    assign stall_timeout   = (stall_q == 8'(STALL_LIMIT));
endmodule

// File: tb/tb_ysyx_25040129_idu_operand_stage.sv
// tb/tb_ysyx_25040129_idu_operand_stage.sv - self-checking bench for the operand resolve / issue stage
module tb_ysyx_25040129_idu_operand_stage;
    localparam int NF = 3;
    localparam int DP = 2;

    typedef struct {
        logic [31:0] s1;
        logic [31:0] s2;
        logic [3:0]  rd;
        logic        we;
        logic [63:0] pl;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [31:0]      rf_rdata1, rf_rdata2;
    logic [NF*4-1:0]  fwd_rd;
    logic [NF-1:0]    fwd_we, fwd_data_valid;
    logic [NF*32-1:0] fwd_data;
    logic             flush;
    logic [7:0]       stall_cycles;
    logic             stall_timeout;

    int   total = 0;
    int   bad = 0;
    ent_t mq[$];
    int   m_stall = 0;

    ysyx_25040129_idu_operand_stage_if #(.XLEN(32), .REG_AW(4), .PAYLOAD_W(64)) bus ();

    ysyx_25040129_idu_operand_stage #(
        .XLEN(32), .REG_AW(4), .NUM_FWD(NF), .DEPTH(DP), .PAYLOAD_W(64), .STALL_LIMIT(255)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .rf_rdata1      (rf_rdata1),
        .rf_rdata2      (rf_rdata2),
        .fwd_rd         (fwd_rd),
        .fwd_we         (fwd_we),
        .fwd_data_valid (fwd_data_valid),
        .fwd_data       (fwd_data),
        .flush          (flush),
        .stall_cycles   (stall_cycles),
        .stall_timeout  (stall_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_fwd(input int c, input logic [3:0] rd, input logic we, input logic dv, input logic [31:0] d);
        fwd_rd[c*4 +: 4]     = rd;
        fwd_we[c]            = we;
        fwd_data_valid[c]    = dv;
        fwd_data[c*32 +: 32] = d;
    endtask

    task automatic set_in(input logic v, input logic [3:0] rs1, input logic u1, input logic [3:0] rs2,
                          input logic u2, input logic [3:0] rd, input logic we, input logic [63:0] pl);
        bus.in_valid    = v;
        bus.in_rs1      = rs1;
        bus.in_rs1_used = u1;
        bus.in_rs2      = rs2;
        bus.in_rs2_used = u2;
        bus.in_rd       = rd;
        bus.in_rd_we    = we;
        bus.in_payload  = pl;
    endtask

    task automatic idle();
        set_in(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 64'd0);
        fwd_rd = '0; fwd_we = '0; fwd_data_valid = '0; fwd_data = '0;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        rf_rdata1 = 32'h1111_0001;
        rf_rdata2 = 32'h2222_0002;
    endtask

    // Reference resolution: youngest queued writer stalls; else first matching channel forwards or stalls; else RF.
    function automatic void model_src(input logic [3:0] rs, input logic used, input logic [31:0] rf,
                                      output logic [31:0] d, output logic hz);
        d  = rf;
        hz = 1'b0;
        if (!used || rs == 4'd0) return;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].we && mq[i].rd == rs) begin
                hz = 1'b1;
                return;
            end
        end
        for (int c = 0; c < NF; c++) begin
            if (fwd_we[c] && fwd_rd[c*4 +: 4] == rs) begin
                if (fwd_data_valid[c]) d = fwd_data[c*32 +: 32];
                else hz = 1'b1;
                return;
            end
        end
    endfunction

    // One clock: called just after a falling edge with inputs already set; checks, then advances the model.
    task automatic step();
        logic [31:0] d1, d2;
        logic        h1, h2, hz, exp_ready, acc, pop;
        ent_t        e;
        #1;
        model_src(bus.in_rs1, bus.in_rs1_used, rf_rdata1, d1, h1);
        model_src(bus.in_rs2, bus.in_rs2_used, rf_rdata2, d2, h2);
        hz        = bus.in_valid && (h1 || h2);
        exp_ready = (mq.size() < DP) && !hz && !flush;
        chk("in_ready", bus.in_ready, exp_ready);
        chk("out_valid", bus.out_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("out_src1", bus.out_src1, mq[0].s1);
            chk("out_src2", bus.out_src2, mq[0].s2);
            chk("out_rd", bus.out_rd, mq[0].rd);
            chk("out_rd_we", bus.out_rd_we, mq[0].we);
            chk("out_payload", bus.out_payload, mq[0].pl);
        end
        chk("stall_cycles", stall_cycles, m_stall);
        chk("stall_timeout", stall_timeout, m_stall == 255);
        acc = bus.in_valid && exp_ready;
        pop = (mq.size() != 0) && bus.out_ready;
        e.s1 = d1; e.s2 = d2; e.rd = bus.in_rd; e.we = bus.in_rd_we; e.pl = bus.in_payload;
        @(posedge clk);
        if (flush) begin
            mq.delete();
            m_stall = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(e);
            if (!bus.in_valid || acc) m_stall = 0;
            else if (hz && m_stall < 255) m_stall++;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        idle();
        bus.out_ready = 1'b1;
        repeat (3) step();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        idle();
        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_src1", bus.out_src1, 32'd0);
        chk("rst_out_payload", bus.out_payload, 64'd0);
        chk("rst_stall", stall_cycles, 8'd0);
        chk("rst_timeout", stall_timeout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: youngest channel wins
        set_fwd(0, 4'd3, 1'b1, 1'b1, 32'h0000_AAAA);
        set_fwd(1, 4'd3, 1'b1, 1'b1, 32'h0000_5555);
        set_in(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd7, 1'b1, 64'h101);
        step();
        bus.in_valid = 1'b0;
        #1;
        chk("t1_out_valid", bus.out_valid, 1'b1);
        chk("t1_out_src1", bus.out_src1, 32'h0000_AAAA);
        drain();

        // 2: youngest channel pending -> stall even though an older one has data
        set_fwd(0, 4'd5, 1'b1, 1'b0, 32'h0);
        set_fwd(2, 4'd5, 1'b1, 1'b1, 32'h99);
        set_in(1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 4'd8, 1'b0, 64'h202);
        repeat (3) step();
        #1;
        chk("t2_stall3", stall_cycles, 8'd3);
        set_fwd(0, 4'd5, 1'b1, 1'b1, 32'h77);
        step();
        bus.in_valid = 1'b0;
        #1;
        chk("t2_out_src2", bus.out_src2, 32'h77);
        chk("t2_stall_clr", stall_cycles, 8'd0);
        drain();

        // 3: buffered writer blocks a dependent, forwarding releases it after the pop
        set_in(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 64'h303);
        step();
        set_in(1'b1, 4'd4, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 64'h304);
        #1;
        chk("t3_blocked", bus.in_ready, 1'b0);
        step();
        bus.out_ready = 1'b1;
        set_fwd(0, 4'd4, 1'b1, 1'b1, 32'h1234);
        step();
        step();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("t3_out_src1", bus.out_src1, 32'h1234);
        drain();

        // 4: capacity and FIFO order
        set_in(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b0, 64'hA1);
        step();
        bus.in_payload = 64'hA2;
        step();
        bus.in_payload = 64'hA3;
        #1;
        chk("t4_full", bus.in_ready, 1'b0);
        step();
        #1;
        chk("t4_head_hold", bus.out_payload, 64'hA1);
        bus.out_ready = 1'b1;
        step();
        #1;
        chk("t4_head2", bus.out_payload, 64'hA2);
        step();
        bus.in_valid = 1'b0;
        step();
        drain();

        // 5: flush with a full buffer and a pending instruction
        set_in(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 64'hB1);
        step();
        bus.in_payload = 64'hB2;
        step();
        flush = 1'b1;
        bus.in_payload = 64'hB3;
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("t5_empty", bus.out_valid, 1'b0);
        chk("t5_stall", stall_cycles, 8'd0);
        step();

        // 6: saturation then asynchronous reset mid-run
        set_in(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 64'hC1);
        step();
        set_fwd(0, 4'd5, 1'b1, 1'b0, 32'h0);
        set_in(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd10, 1'b1, 64'hC2);
        repeat (300) step();
        #1;
        chk("t6_sat", stall_cycles, 8'd255);
        chk("t6_timeout", stall_timeout, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", bus.out_valid, 1'b0);
        chk("t6_rst_src1", bus.out_src1, 32'd0);
        chk("t6_rst_payload", bus.out_payload, 64'd0);
        chk("t6_rst_stall", stall_cycles, 8'd0);
        chk("t6_rst_timeout", stall_timeout, 1'b0);
        mq.delete();
        m_stall = 0;
        idle();
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            set_in(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 7)), 1'($urandom), 4'($urandom_range(0, 7)),
                   1'($urandom), 4'($urandom_range(0, 7)), 1'($urandom), {$urandom, $urandom});
            for (int c = 0; c < NF; c++) begin
                set_fwd(c, 4'($urandom_range(0, 7)), 1'($urandom), ($urandom_range(0, 3) != 0), $urandom);
            end
            rf_rdata1 = $urandom;
            rf_rdata2 = $urandom;
            bus.out_ready = 1'($urandom);
            flush = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ysyx_25040129_idu_operand_stage.md
Name: ysyx_25040129_idu_operand_stage

Overview:
- Parametrised operand-resolve and issue stage between decode and EXU.
- Takes decoded instructions from IFU/decode over valid/ready and reads source registers.
- Resolves RAW hazards against an internal scoreboard of buffered instructions plus NUM_FWD forwarding channels.
- Queues resolved instructions in a DEPTH-entry issue buffer with a valid/ready handshake toward EXU, adding flush and stall-watchdog support.

Parameters:
XLEN, 32, datapath width
REG_AW, 4, register index width (RV32E)
NUM_FWD, 3, forwarding channels; index 0 = youngest stage (EXU), ascending = older
DEPTH, 2, issue buffer entries (>=1)
PAYLOAD_W, 64, opaque decoded-control bits carried unchanged
STALL_LIMIT, 255, saturation value of the stall counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  decoded instruction valid
in_ready  out  1  stage accepts instruction this cycle
in_rs1, in_rs2  in  REG_AW each  source indices
in_rs1_used, in_rs2_used  in  1 each  source read from register file
in_rd  in  REG_AW  destination index
in_rd_we  in  1  instruction writes rd
in_payload  in  PAYLOAD_W  opaque control
rf_rdata1, rf_rdata2  in  XLEN each  register-file read data (combinational)
fwd_rd  in  NUM_FWD*REG_AW  pending destination per channel
fwd_we  in  NUM_FWD  channel holds valid rd write
fwd_data_valid  in  NUM_FWD  channel result available
fwd_data  in  NUM_FWD*XLEN  channel result
flush  in  1  discard buffer and incoming instruction
out_valid  out  1  issue buffer head valid
out_ready  in  1  EXU accepts head
out_src1, out_src2  out  XLEN each  resolved operands
out_rd  out  REG_AW  destination index
out_rd_we  out  1  write enable
out_payload  out  PAYLOAD_W  control
stall_cycles  out  8  consecutive hazard-stall cycles, saturating
stall_timeout  out  1  stall_cycles == STALL_LIMIT

Behaviour:
- Reset (rst_n low, async): buffer empty, out_valid=0, stall_cycles=0, stall_timeout=0. out_src1/out_src2/out_rd/out_rd_we/out_payload=0.
- Per source (rs1, rs2), evaluated only when *_used=1 and rs!=0. Sources with rs==0 or *_used=0 pass rf_rdata unchanged (x0 reads 0 from RF).
- Match search, youngest first: buffer entries, tail to head, then fwd channels 0..NUM_FWD-1. The first match decides:
  - Buffer entry with rd_we=1 and rd==rs: hazard. Its value is not yet computed.
  - Channel with fwd_we=1 and fwd_rd==rs: if fwd_data_valid, forward fwd_data; else hazard.
  - Older matches are never consulted once a younger match is found.
  - No match: use rf_rdata.
- hazard = in_valid & (src1 hazard | src2 hazard).
- in_ready = (count < DEPTH) & ~hazard & ~flush. Purely combinational; no same-cycle pop pass-through (full buffer with out_ready=1 still gives in_ready=0).
- Accept = in_valid & in_ready: push {resolved src1, src2, rd, rd_we, payload} at tail. Visible at out_valid no earlier than the next cycle (1-cycle latency when empty).
- Pop = out_valid & out_ready: head advances. Push and pop in the same cycle keep count unchanged; ordering is FIFO.
- Out fields show the head entry. They hold stable while out_valid & ~out_ready.
- flush=1: next cycle buffer empty, out_valid=0. Same-cycle incoming instruction dropped, pop ignored, stall_cycles cleared.
- stall_cycles: +1 per cycle with in_valid & hazard & ~flush, saturating at STALL_LIMIT. Cleared on accept, flush, or in_valid=0.
- stall_timeout is combinational from the counter.
- Async reset during a transfer discards all entries immediately.
- Pointers wrap modulo DEPTH. count is held in a separate register so full and empty are unambiguous.

Test Plan:
1. Empty stage: in rs1=3, fwd ch0 rd=3 we=1 dv=1 data=0xAAAA, ch1 rd=3 data=0x5555 -> accept; next cycle out_valid=1, out_src1=0xAAAA (youngest channel wins).
2. Ch0 rd=5 we=1 dv=0, ch2 rd=5 dv=1, in rs2=5 used -> in_ready=0 held; stall_cycles 0,1,2...; set ch0 dv=1 data=0x77 -> accept, out_src2=0x77, stall_cycles=0.
3. Back-to-back: instr A rd=4 we=1 accepted, out_ready=0; instr B rs1=4 -> in_ready=0 (buffer scoreboard). Pop A, fwd ch0 rd=4 dv=1 -> B accepted.
4. DEPTH=2, out_ready=0, push 3 instrs with no hazards -> first two accepted, third sees in_ready=0. out_payload holds the first. Toggle out_ready -> FIFO order preserved.
5. Buffer holds 2 entries, in_valid=1, flush=1 for one cycle -> next cycle out_valid=0, nothing pushed, stall_cycles=0.
6. Permanent hazard for 300 cycles -> stall_cycles saturates at 255 and stall_timeout=1. Assert rst_n=0 mid-run -> all outputs 0 immediately.
